// File: rtl/dmem_lsu.sv
// dmem_lsu: data-memory load/store unit with valid/ready request and response.
// Optional store trace under `define DMEM_TRACE_EN.
module dmem_lsu #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-3:0] idx;
    logic [1:0]        lane;
    logic              accept;
    logic              bad;
    logic              do_wr;
    logic [31:0]       word;
    logic [31:0]       wmerged;
    logic [31:0]       ldata;
    logic [7:0]        lbyte;
    logic [15:0]       lhalf;
    logic              unused_ok;

    assign idx       = req_addr[ADDR_W-1:2];
    assign lane      = req_addr[1:0];
    assign word      = mem[idx];
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid & req_ready;
    assign do_wr     = accept & req_we & ~bad;
    assign unused_ok = ^{req_addr[31:ADDR_W], req_pc};

    // Misalignment and illegal-size detection.
    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            req_size == 2'b11: bad = 1'b1;
            req_size == 2'b01: bad = req_addr[0];
            req_size == 2'b10: bad = |req_addr[1:0];
            default:           bad = 1'b0;
        endcase
    end

    // Merge store data into the addressed byte lanes.
    always_comb begin
        wmerged = word;
        unique case (req_size)
            2'b00:   wmerged[{lane, 3'b000} +: 8] = req_wdata[7:0];
            2'b01:   wmerged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
            2'b10:   wmerged = req_wdata;
            default: wmerged = word;
        endcase
    end

    // Extract and extend load data from the addressed word.
    always_comb begin
        lbyte = word[{lane, 3'b000} +: 8];
        lhalf = word[{req_addr[1], 4'b0000} +: 16];
        unique case (req_size)
            2'b00: ldata = req_unsigned ? {24'b0, lbyte}
                                        : {{24{lbyte[7]}}, lbyte};
            2'b01: ldata = req_unsigned ? {16'b0, lhalf}
                                        : {{16{lhalf[15]}}, lhalf};
            default: ldata = word;
        endcase
    end

    // Next-state and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    err_d   = bad;
                    rdata_d = (bad | req_we) ? 32'b0 : ldata;
                    if (bad | req_we | (RD_LAT <= 1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 2'(RD_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[idx] <= wmerged;
`ifdef DMEM_TRACE_EN
            $display("pc = %h: dataaddr = %h, memdata = %h",
                     req_pc, {req_addr[31:2], 2'b00}, wmerged);
`endif
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized and directed checks of dmem_lsu
// against a byte-array memory model.
module tb_dmem_lsu;

    localparam int ADDR_W = 12;
    localparam int RD_LAT = 3;
    localparam int MB     = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mbytes [MB];
    logic [31:0] got_rd;
    logic        got_err;

    dmem_lsu #(
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_pc      (req_pc),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns,
                                  output logic [31:0] rd, output logic er);
        int n;
        int a;
        n  = 1 << size;
        a  = int'(addr & 32'(MB - 1));
        er = (size == 2'b11) || ((addr % 32'(n)) != 0);
        rd = 32'b0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < n; i++) mbytes[a + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++)
                    rd = rd | (32'(mbytes[a + i]) << (8 * i));
                if (n < 4 && !uns && rd[8*n-1])
                    rd = rd | (32'hFFFF_FFFF << (8 * n));
            end
        end
    endfunction

    task automatic run(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size,
                       input logic uns, input int hold);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        model(we, addr, wdata, size, uns, exp_rd, exp_err);
        exp_lat = (!we && !exp_err) ? RD_LAT : 1;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_pc       = $urandom;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 20);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rdata", rsp_rdata, exp_rd);
        check("err", 32'(rsp_err), 32'(exp_err));
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_busy", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_ready", 32'(req_ready), 32'd1);
        check("post_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'b0;
        req_wdata    = 32'b0;
        req_size     = 2'b0;
        req_unsigned = 1'b0;
        req_pc       = 32'b0;
        rsp_ready    = 1'b0;
        for (int i = 0; i < MB; i++) mbytes[i] = 8'h00;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int w = 0; w < MB / 4; w++) run(1'b1, 32'(w * 4), 32'd0, 2'b10, 1'b0, 0);

        run(1'b1, 32'h10, 32'h1122_3344, 2'b10, 1'b0, 0);
        run(1'b1, 32'h12, 32'h0000_00AA, 2'b00, 1'b0, 0);
        run(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0);
        check("lw_merge", got_rd, 32'h11AA_3344);

        run(1'b1, 32'h22, 32'h0000_8001, 2'b01, 1'b0, 0);
        run(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 0);
        check("lh", got_rd, 32'hFFFF_8001);
        run(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 0);
        check("lhu", got_rd, 32'h0000_8001);
        run(1'b0, 32'h23, 32'h0, 2'b00, 1'b0, 0);
        check("lb", got_rd, 32'hFFFF_FF80);

        run(1'b0, 32'h21, 32'h0, 2'b10, 1'b0, 0);
        check("lw_mis_err", 32'(got_err), 32'd1);
        run(1'b1, 32'h13, 32'hFFFF_FFFF, 2'b01, 1'b0, 0);
        check("sh_mis_err", 32'(got_err), 32'd1);
        run(1'b1, 32'h0, 32'hFFFF_FFFF, 2'b11, 1'b0, 0);
        check("size3_err", 32'(got_err), 32'd1);
        run(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0);
        check("err_nowrite", got_rd, 32'h11AA_3344);

        run(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5);

        run(1'b1, 32'h1004, 32'hDEAD_BEEF, 2'b10, 1'b0, 0);
        run(1'b0, 32'h0004, 32'h0, 2'b10, 1'b0, 0);
        check("wrap", got_rd, 32'hDEAD_BEEF);

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_size  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rstn      = 1'b0;
        #1;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0);
        check("midrst_ram", got_rd, 32'h11AA_3344);

        for (int k = 0; k < 400; k++) begin
            a  = $urandom;
            sz = 2'($urandom_range(3));
            if ($urandom_range(3) != 0 && sz != 2'b11)
                a = a & ~((32'd1 << sz) - 32'd1);
            run(1'($urandom_range(1)), a, $urandom, sz,
                1'($urandom_range(1)), int'($urandom_range(2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data-memory load/store unit for the xgriscv pipeline, the successor to the single-cycle data memory. It accepts one load or store request at a time over a valid/ready handshake and performs byte, half, or word stores with lane merging. Loads are sign- or zero-extended, and misaligned or illegal accesses are reported as errors. Read latency is configurable, and every request returns one response that is held until the MEM stage takes it.

## Interface
Parameters:
- ADDR_W, 12: byte-address bits decoded; word index = req_addr[ADDR_W-1:2]; depth = 2^(ADDR_W-2) words.
- RD_LAT, 1: load latency in cycles, legal 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [31:ADDR_W] ignored (address wraps).
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend load (lbu/lhu).
- req_pc  in  32  PC of the access, used for trace only.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal access.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch the request; then:
  - error → RESP;
  - store → commit write at the same edge, → RESP;
  - load → capture word RAM[idx], → WAIT with counter = RD_LAT-1, or directly to RESP if RD_LAT=1.
- WAIT: counter decrements each cycle; at 0 → RESP.
- RESP: rsp_valid=1; outputs stable until rsp_ready=1, then → IDLE.
- Error cases:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0.
  - An errored store writes nothing.
- Store merge (lane = addr[1:0]):
  - byte: wdata[7:0] into lane;
  - half: wdata[15:0] into bytes {addr[1],1'b1}:{addr[1],1'b0};
  - word: full replace.
  - Untouched bytes are preserved.
- Load extract:
  - byte selects lane;
  - half selects addr[1];
  - extension is sign, unless req_unsigned=1 (zero);
  - req_unsigned is ignored for word.
- Load data reflects memory at the accept edge. With one request outstanding, there is no read/write hazard.

## Timing
- Reset:
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; counter=0.
  - RAM contents are not reset.
- Accept at edge N. Store/error: rsp_valid high after edge N+1. Load: rsp_valid high after edge N+RD_LAT.
- Handshake: a request transfers on req_valid&req_ready at an edge. A response transfers on rsp_valid&rsp_ready at an edge. req_ready returns to 1 the cycle after the response transfers; no same-cycle re-accept.
- Best-case throughput: one access per RD_LAT+1 cycles for loads and 2 cycles for stores.
- rsp_ready held low: rsp_valid/rsp_rdata/rsp_err hold indefinitely.
- Reset mid-operation: the pending response is discarded and the state returns to IDLE. A store committed before reset remains in RAM.
- Address wrap: req_addr = 2^ADDR_W + k accesses the same word as k.

## Configuration
- DMEM_TRACE_EN defined: each committed store prints, at the commit edge, "pc = %h: dataaddr = %h, memdata = %h". The arguments are req_pc, {addr[31:2],2'b00}, and the merged word.
- Not defined: no display statements; functionally identical.

## Test plan
- Reset with rstn=0 mid-WAIT (RD_LAT=3) → rsp_valid=0, req_ready=1 immediately; RAM unchanged.
- Store word 0x11223344 @0x10, then sb 0xAA @0x12, then lw @0x10 → rsp_rdata=0x11AA3344, rsp_err=0, rsp_valid exactly RD_LAT cycles after accept.
- sh 0x8001 @0x22, then lh @0x22 → 0xFFFF8001; lhu @0x22 → 0x00008001; lb @0x23 → 0xFFFFFF80.
- lw @0x21, sh @0x13, size 11 @0x0 → each rsp_err=1, rsp_rdata=0, memory unchanged; response after 1 cycle.
- Load with rsp_ready held low 5 cycles → rsp_valid/rsp_rdata stable, req_ready=0 throughout; after transfer, req_ready=1 next cycle.
- ADDR_W=12: store 0xDEADBEEF @0x1004, load @0x0004 → 0xDEADBEEF (wrap).
